rs485_uart_rx: RTL and testbench
================================

RS485_UART_RX -- requirements
Module: rs485_uart_rx

Interface
REQ-001 The block SHALL provide parameter CLK_FREQ, default 50000000, meaning sys_clk frequency in Hz.
REQ-002 The block SHALL provide parameter UART_BPS, default 115200, meaning the serial bit rate.
REQ-003 The block SHALL have port sys_clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port sys_rst, input, 1 bit, the synchronous active-high reset.
REQ-005 The block SHALL have port rs485_rxd, input, 1 bit, the asynchronous serial line from the RS485 transceiver; it idles high.
REQ-006 The block SHALL have port rx_out_data, output, 8 bits, the last correctly framed received byte, held between frames.
REQ-007 The block SHALL have port rx_done, output, 1 bit, a one-cycle pulse when rx_out_data is updated.
REQ-008 The block SHALL have port rx_frame_err, output, 1 bit, a one-cycle pulse when a stop bit is sampled low.
REQ-009 The block SHALL have port rx_busy, output, 1 bit, high in every state except IDLE.

Function
REQ-010 rs485_rxd SHALL pass through a 2-flop synchronizer, and a third flop SHALL provide edge detection; all decisions use the synchronized value.
REQ-011 BPS_CNT SHALL equal CLK_FREQ/UART_BPS, truncated as an integer (434 at the defaults); the bit counter SHALL be wide enough for BPS_CNT-1.
REQ-012 The frame format SHALL be 8N1: 1 start bit (low), 8 data bits LSB first, 1 stop bit (high); there is no parity.
REQ-013 The state machine SHALL have the states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-014 In IDLE, a synchronized falling edge SHALL clear the bit counter and move to START.
REQ-015 In START, at count BPS_CNT/2-1 (mid start bit) the line SHALL be sampled: if low, the counter clears and the block moves to DATA; if high, the edge is a glitch and the block returns to IDLE with no output change.
REQ-016 In DATA, each bit SHALL be sampled when the counter reaches BPS_CNT-1, which is the mid-bit point because of the START alignment.
REQ-017 Each sampled data bit SHALL shift into a shift register at bit index 0..7, LSB first; after bit 7 the block moves to STOP.
REQ-018 In STOP, at mid stop bit, a high sample SHALL load rx_out_data from the shift register, pulse rx_done for exactly one cycle, and return to IDLE.
REQ-019 In STOP, at mid stop bit, a low sample SHALL pulse rx_frame_err for exactly one cycle, leave rx_out_data unchanged, and move to WAIT_IDLE.
REQ-020 WAIT_IDLE SHALL stay until the synchronized line is high, then go to IDLE; this covers break conditions and prevents false restarts.
REQ-021 rx_done and rx_frame_err SHALL never be high in the same cycle.
REQ-022 Because the return to IDLE happens at mid stop bit, a new falling edge arriving immediately after the stop bit SHALL be accepted, so back-to-back frames are received without loss.
REQ-023 Edges on rs485_rxd outside IDLE SHALL NOT restart or disturb a frame in progress.
REQ-024 rx_out_data SHALL NOT change except on the cycle rx_done is asserted.

Reset
REQ-025 While sys_rst is high at a clock edge, the block SHALL set: state = IDLE, counters = 0, shift register = 0x00, rx_out_data = 0x00, rx_done = 0, rx_frame_err = 0, rx_busy = 0.
REQ-026 The synchronizer flops SHALL reset to 1 (line idle), so that release of reset never creates a false falling edge.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no rx_done or rx_frame_err pulse; after release, the block waits for a fresh falling edge.

Verification
REQ-028 Scenario: send 0x55 at 115200 baud (434 cycles/bit) -> rx_out_data = 0x55 and a single rx_done pulse about 9.5×434 = 4123 cycles (±3 cycles of synchronizer delay) after the falling edge; rx_busy is high throughout.
REQ-029 Scenario: send 0xA3 then 0x0F back-to-back with no idle gap -> two rx_done pulses, with rx_out_data = 0xA3 and then 0x0F, and no rx_frame_err.
REQ-030 Scenario: a 100-cycle low glitch on an idle line -> the block returns to IDLE at mid start bit, with no rx_done, no rx_frame_err, and rx_out_data unchanged.
REQ-031 Scenario: send frame 0x3C with the stop bit forced low, then hold the line low for 2000 cycles -> one rx_frame_err pulse, rx_out_data keeps its prior value, the block stays in WAIT_IDLE until the line rises, and the next frame 0x81 is received correctly.
REQ-032 Scenario: assert sys_rst for 2 cycles during data bit 4 of frame 0xFF -> all outputs at reset values with no pulses, and a following frame 0x12 yields rx_out_data = 0x12.
REQ-033 Scenario: run with parameters CLK_FREQ = 50000000 and UART_BPS = 9600 (5208 cycles/bit), send 0xC6 -> rx_out_data = 0xC6 and one rx_done pulse.

Source files
------------

// File: rtl/rs485_uart_rx.sv
`default_nettype none
// ============================================================================
// rs485_uart_rx : 8N1 serial receiver for an RS485 transceiver, mid-bit sampling
// Revision 1.0 : initial release
// ============================================================================
module rs485_uart_rx #(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 115200
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       rs485_rxd,
  output logic [7:0] rx_out_data,
  output logic       rx_done,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int c_BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int c_CNT_W   = (c_BPS_CNT > 2) ? $clog2(c_BPS_CNT) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(c_BPS_CNT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(c_BPS_CNT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_rxd_s1;
  logic                 r_rxd_s2;
  logic                 r_rxd_s3;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [2:0]           r_bit_idx;
  logic [7:0]           r_shift;
  logic                 w_fall;
  logic                 w_half_hit;
  logic                 w_full_hit;
  logic                 w_cnt_clr;
  logic                 w_bit_take;
  logic                 w_load;
  logic                 w_err;

  // Synchronizer idles high so leaving reset never looks like a start edge
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_rxd_s1 <= 1'b1;
      r_rxd_s2 <= 1'b1;
      r_rxd_s3 <= 1'b1;
    end else begin
      r_rxd_s1 <= rs485_rxd;
      r_rxd_s2 <= r_rxd_s1;
      r_rxd_s3 <= r_rxd_s2;
    end
  end

  assign w_fall     = r_rxd_s3 & ~r_rxd_s2;
  assign w_half_hit = (r_cnt == c_CNT_HALF);
  assign w_full_hit = (r_cnt == c_CNT_FULL);
  assign rx_busy    = (r_state != IDLE);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_clr    = 1'b0;
    w_bit_take   = 1'b0;
    w_load       = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_cnt_clr    = 1'b1;
          w_state_next = START;
        end
      end
      START: begin
        // Re-check the line half a bit in; a high level means it was a glitch
        if (w_half_hit) begin
          w_cnt_clr    = 1'b1;
          w_state_next = r_rxd_s2 ? IDLE : DATA;
        end
      end
      DATA: begin
        if (w_full_hit) begin
          w_cnt_clr  = 1'b1;
          w_bit_take = 1'b1;
          if (r_bit_idx == 3'd7) begin
            w_state_next = STOP;
          end
        end
      end
      STOP: begin
        if (w_full_hit) begin
          w_cnt_clr = 1'b1;
          if (r_rxd_s2) begin
            w_load       = 1'b1;
            w_state_next = IDLE;
          end else begin
            w_err        = 1'b1;
            w_state_next = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (r_rxd_s2) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_cnt <= '0;
    end else if (w_cnt_clr || (r_state == IDLE) || (r_state == WAIT_IDLE)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
    end else begin
      if (r_state != DATA) begin
        r_bit_idx <= 3'd0;
      end else if (w_bit_take) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end
      if (w_bit_take) begin
        r_shift[r_bit_idx] <= r_rxd_s2;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_out_data  <= 8'h00;
      rx_done      <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_done      <= w_load;
      rx_frame_err <= w_err;
      if (w_load) begin
        rx_out_data <= r_shift;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rs485_uart_rx.sv
`default_nettype none
// ============================================================================
// tb_rs485_uart_rx : scoreboard bench for rs485_uart_rx at 115200 and 9600 baud
// Revision 1.0 : initial release
// ============================================================================
module tb_rs485_uart_rx;

  localparam int c_BIT_F = 434;
  localparam int c_BIT_S = 5208;

  logic       clk = 1'b0;
  logic       rst_f = 1'b1;
  logic       rst_s = 1'b1;
  logic       rxd_f = 1'b1;
  logic       rxd_s = 1'b1;
  logic [7:0] data_f, data_s;
  logic       done_f, done_s, err_f, err_s, busy_f, busy_s;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] q_f[$];
  logic [7:0] q_s[$];
  int  done_cnt_f = 0, err_cnt_f = 0, done_cnt_s = 0, err_cnt_s = 0;
  int  last_done_cyc = 0;
  int  watch_t0 = 0;
  bit  watch_en = 1'b0;
  int  busy_drop = 0;
  logic       rst_at_edge = 1'b1;
  logic [7:0] prev_f = 8'h00;

  always #10 clk = ~clk;

  rs485_uart_rx dut (
    .sys_clk      (clk),
    .sys_rst      (rst_f),
    .rs485_rxd    (rxd_f),
    .rx_out_data  (data_f),
    .rx_done      (done_f),
    .rx_frame_err (err_f),
    .rx_busy      (busy_f)
  );

  rs485_uart_rx #(.CLK_FREQ(50000000), .UART_BPS(9600)) dut_slow (
    .sys_clk      (clk),
    .sys_rst      (rst_s),
    .rs485_rxd    (rxd_s),
    .rx_out_data  (data_s),
    .rx_done      (done_s),
    .rx_frame_err (err_s),
    .rx_busy      (busy_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_line(input bit sel, input logic v);
    if (sel) rxd_s = v;
    else     rxd_f = v;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input logic stop, input int bc);
    set_line(sel, 1'b0);
    repeat (bc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_line(sel, d[i]);
      repeat (bc) @(negedge clk);
    end
    set_line(sel, stop);
    repeat (bc) @(negedge clk);
  endtask

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst_f;
  end

  always @(negedge clk) begin
    if (done_f && err_f) chk("done_err_excl", 32'd1, 32'd0);
    if (done_f) begin
      done_cnt_f++;
      last_done_cyc = cyc;
      watch_en = 1'b0;
      if (q_f.size() == 0) chk("sb_unexpected_f", {24'd0, data_f}, 32'hFFFF_FFFF);
      else                 chk("sb_data_f", {24'd0, data_f}, {24'd0, q_f.pop_front()});
    end else if (!rst_at_edge) begin
      chk("data_stable", {24'd0, data_f}, {24'd0, prev_f});
    end
    if (err_f) err_cnt_f++;
    if (watch_en && (cyc >= watch_t0 + 4) && !busy_f) busy_drop++;
    prev_f = data_f;
  end

  always @(negedge clk) begin
    if (done_s && err_s) chk("done_err_excl_s", 32'd1, 32'd0);
    if (done_s) begin
      done_cnt_s++;
      if (q_s.size() == 0) chk("sb_unexpected_s", {24'd0, data_s}, 32'hFFFF_FFFF);
      else                 chk("sb_data_s", {24'd0, data_s}, {24'd0, q_s.pop_front()});
    end
    if (err_s) err_cnt_s++;
  end

  initial begin
    int t0, dc, ec;
    repeat (3) @(negedge clk);
    rst_f = 1'b0;
    rst_s = 1'b0;
    chk("rst_data", {24'd0, data_f}, 32'h00);
    chk("rst_done", {31'd0, done_f}, 32'd0);
    chk("rst_err",  {31'd0, err_f},  32'd0);
    chk("rst_busy", {31'd0, busy_f}, 32'd0);
    repeat (20) @(negedge clk);

    fork
      begin : slow_line
        q_s.push_back(8'hC6);
        send_frame(1'b1, 8'hC6, 1'b1, c_BIT_S);
        repeat (200) @(negedge clk);
      end
      begin : fast_line
        // single frame, latency and busy coverage
        q_f.push_back(8'h55);
        t0 = cyc;
        watch_t0 = t0;
        watch_en = 1'b1;
        send_frame(1'b0, 8'h55, 1'b1, c_BIT_F);
        chk("lat_55_in_window", {31'd0, (last_done_cyc - t0 >= 4120) && (last_done_cyc - t0 <= 4126)}, 32'd1);
        chk("busy_through_55", busy_drop, 0);
        chk("data_55", {24'd0, data_f}, 32'h55);
        repeat (300) @(negedge clk);

        // back-to-back frames
        ec = err_cnt_f;
        q_f.push_back(8'hA3);
        send_frame(1'b0, 8'hA3, 1'b1, c_BIT_F);
        q_f.push_back(8'h0F);
        send_frame(1'b0, 8'h0F, 1'b1, c_BIT_F);
        chk("b2b_done_cnt", done_cnt_f, 3);
        chk("b2b_no_err", err_cnt_f - ec, 0);
        chk("b2b_data", {24'd0, data_f}, 32'h0F);
        repeat (300) @(negedge clk);

        // start-bit glitch
        dc = done_cnt_f;
        ec = err_cnt_f;
        rxd_f = 1'b0;
        repeat (100) @(negedge clk);
        rxd_f = 1'b1;
        repeat (600) @(negedge clk);
        chk("glitch_no_done", done_cnt_f - dc, 0);
        chk("glitch_no_err", err_cnt_f - ec, 0);
        chk("glitch_data", {24'd0, data_f}, 32'h0F);
        chk("glitch_idle", {31'd0, busy_f}, 32'd0);

        // framing error followed by a break
        dc = done_cnt_f;
        ec = err_cnt_f;
        send_frame(1'b0, 8'h3C, 1'b0, c_BIT_F);
        repeat (2000) @(negedge clk);
        chk("ferr_one_pulse", err_cnt_f - ec, 1);
        chk("ferr_no_done", done_cnt_f - dc, 0);
        chk("ferr_data_kept", {24'd0, data_f}, 32'h0F);
        chk("ferr_wait_idle_busy", {31'd0, busy_f}, 32'd1);
        rxd_f = 1'b1;
        repeat (20) @(negedge clk);
        chk("ferr_back_idle", {31'd0, busy_f}, 32'd0);
        q_f.push_back(8'h81);
        send_frame(1'b0, 8'h81, 1'b1, c_BIT_F);
        chk("after_ferr_data", {24'd0, data_f}, 32'h81);
        repeat (300) @(negedge clk);

        // reset during data bit 4
        dc = done_cnt_f;
        ec = err_cnt_f;
        fork
          send_frame(1'b0, 8'hFF, 1'b1, c_BIT_F);
          begin
            repeat (c_BIT_F * 5 + 200) @(negedge clk);
            rst_f = 1'b1;
            repeat (2) @(negedge clk);
            rst_f = 1'b0;
            chk("midrst_data", {24'd0, data_f}, 32'h00);
            chk("midrst_busy", {31'd0, busy_f}, 32'd0);
            chk("midrst_done", {31'd0, done_f}, 32'd0);
            chk("midrst_err",  {31'd0, err_f},  32'd0);
          end
        join
        repeat (300) @(negedge clk);
        chk("midrst_no_done", done_cnt_f - dc, 0);
        chk("midrst_no_err", err_cnt_f - ec, 0);
        chk("midrst_still_idle", {31'd0, busy_f}, 32'd0);
        q_f.push_back(8'h12);
        send_frame(1'b0, 8'h12, 1'b1, c_BIT_F);
        chk("after_rst_data", {24'd0, data_f}, 32'h12);
        repeat (300) @(negedge clk);
      end
    join

    chk("fast_done_total", done_cnt_f, 5);
    chk("fast_err_total", err_cnt_f, 1);
    chk("fast_sb_empty", q_f.size(), 0);
    chk("slow_done_total", done_cnt_s, 1);
    chk("slow_err_total", err_cnt_s, 0);
    chk("slow_sb_empty", q_s.size(), 0);
    chk("slow_data", {24'd0, data_s}, 32'hC6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
